// File: rtl/aclk_keyscan.sv
// aclk_keyscan -- 3x4 keypad column scanner with scan-based debouncing.
//
// Drives one keypad column at a time. The row inputs are synchronized and
// sampled once per column slot. At the end of each full col0..col2 scan the
// decoded result feeds a press/release debounce FSM. The FSM publishes a
// registered key code and a one-cycle strobe for each accepted press.
//
// Parameters:
//   SCAN_DIV        clk cycles per column slot (4..255)
//   DEBOUNCE_SCANS  consecutive equal scans to accept a press/release (2..15)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   row[3:0]    keypad row sense, active-high, asynchronous to clk
//   col[2:0]    one-hot column drive, active-high
//   key[3:0]    debounced key code 0..9, 10 = no key
//   key_strobe  one-clk pulse when a new key is accepted
//
// Build option:
//   KEYSCAN_MULTI_REJECT_EN  defined: a scan holding two or more digit keys
//                            is rejected (no key). Undefined: the first digit
//                            in col0..col2, row0..row3 order wins.

module aclk_keyscan #(
   parameter int unsigned SCAN_DIV       = 16,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [2:0] col,
   output logic [3:0] key,
   output logic       key_strobe
);

   localparam logic [3:0] KEY_NONE  = 4'd10;
   localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
   localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE,
      CONFIRM_PRESS,
      HELD,
      CONFIRM_RELEASE
   } state_t;

   logic [3:0] row_meta_q, row_sync_q;
   logic [7:0] slot_q;
   logic [2:0] col_q;
   logic [3:0] acc_q, acc_d;
   state_t     state_q, state_d;
   logic [3:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] key_q, key_d;
   logic       strobe_q, strobe_d;

   logic       slot_end, scan_end;
   logic [1:0] col_idx;
   logic [3:0] col_digit;
   logic [2:0] col_hits;
   logic [3:0] result;
   logic [3:0] cnt_inc;

   function automatic logic [3:0] decode_key(input int unsigned r, input logic [1:0] c);
      if (r < 3)
         return 4'(r * 3 + 32'(c) + 1);
      else if (c == 2'd1)
         return 4'd0;
      else
         return KEY_NONE;   // '*' and '#'
   endfunction

   assign slot_end = (slot_q == SLOT_LAST);
   assign scan_end = slot_end && col_q[2];
   assign col_idx  = col_q[1] ? 2'd1 : (col_q[2] ? 2'd2 : 2'd0);
   assign cnt_inc  = cnt_q + 4'd1;

   // First digit in the active column (row0 first) and number of digit hits.
   always_comb begin
      col_digit = KEY_NONE;
      col_hits  = '0;
      for (int unsigned r = 0; r < 4; r++) begin
         if (row_sync_q[r] && decode_key(r, col_idx) != KEY_NONE) begin
            col_hits = col_hits + 3'd1;
            if (col_digit == KEY_NONE)
               col_digit = decode_key(r, col_idx);
         end
      end
   end

   // acc_q carries the first digit of earlier columns in this scan, so it wins
   // over the current column; at scan end this gives the whole-scan result.
   assign acc_d = (acc_q != KEY_NONE) ? acc_q : col_digit;

`ifdef KEYSCAN_MULTI_REJECT_EN
   logic multi_q, multi_d;
   assign multi_d = multi_q || (col_hits > 3'd1) || ((acc_q != KEY_NONE) && (col_hits != 3'd0));
   assign result  = multi_d ? KEY_NONE : acc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         multi_q <= 1'b0;
      else if (slot_end)
         multi_q <= col_q[2] ? 1'b0 : multi_d;
   end
`else
   assign result = acc_d;
`endif

   // Scan timing, synchronizer and per-scan accumulator run regardless of FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_meta_q <= '0;
         row_sync_q <= '0;
         slot_q     <= '0;
         col_q      <= 3'b001;
         acc_q      <= KEY_NONE;
      end else begin
         row_meta_q <= row;
         row_sync_q <= row_meta_q;
         if (slot_end) begin
            slot_q <= '0;
            col_q  <= {col_q[1:0], col_q[2]};
            acc_q  <= col_q[2] ? KEY_NONE : acc_d;
         end else begin
            slot_q <= slot_q + 8'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
      if (scan_end) begin
         unique case (state_q)
            IDLE: begin
               if (result != KEY_NONE) begin
                  state_d = CONFIRM_PRESS;
                  cand_d  = result;
                  cnt_d   = 4'd1;
               end
            end
            CONFIRM_PRESS: begin
               if (result != cand_q) begin
                  state_d = IDLE;
                  cand_d  = KEY_NONE;
                  cnt_d   = '0;
               end else if (cnt_inc == DEB_LAST) begin
                  state_d  = HELD;
                  cnt_d    = '0;
                  strobe_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            HELD: begin
               if (result != cand_q) begin
                  state_d = CONFIRM_RELEASE;
                  cnt_d   = 4'd1;
               end
            end
            CONFIRM_RELEASE: begin
               if (result == cand_q) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end else if (cnt_inc == DEB_LAST) begin
                  state_d = IDLE;
                  cand_d  = KEY_NONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = IDLE;
               cand_d  = KEY_NONE;
               cnt_d   = '0;
            end
         endcase
      end
      key_d = (state_d == HELD || state_d == CONFIRM_RELEASE) ? cand_d : KEY_NONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cand_q   <= KEY_NONE;
         cnt_q    <= '0;
         key_q    <= KEY_NONE;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         strobe_q <= strobe_d;
      end
   end

   assign col        = col_q;
   assign key        = key_q;
   assign key_strobe = strobe_q;

endmodule

// File: tb/tb_aclk_keyscan.sv
// tb_aclk_keyscan -- directed testbench for aclk_keyscan (SCAN_DIV=16,
// DEBOUNCE_SCANS=4). A keypad model drives row from col and the set of
// pressed keys (bit index row*3+col). cyc counts clk edges since reset
// release; with these parameters scan n ends at edge 48*n.

module tb_aclk_keyscan;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row;
   logic [2:0]  col;
   logic [3:0]  key;
   logic        key_strobe;
   logic [11:0] pressed = '0;

   int cyc;
   int scount;
   int nchecks = 0;
   int nerrors = 0;

   aclk_keyscan #(
      .SCAN_DIV       (16),
      .DEBOUNCE_SCANS (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .row        (row),
      .col        (col),
      .key        (key),
      .key_strobe (key_strobe)
   );

   always #5 clk = ~clk;

   always_comb begin
      row = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (pressed[r*3+c] && col[c]) row[r] = 1'b1;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc    <= 0;
         scount <= 0;
      end else begin
         cyc <= cyc + 1;
         if (key_strobe) scount <= scount + 1;
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic start(input logic [11:0] keys);
      reset   = 1'b1;
      pressed = keys;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      pressed = '0;
      @(negedge clk);
      #2;
      nchecks++; if (col !== 3'b001) begin nerrors++; $display("FAIL reset_col: got %b expected 001", col); end
      nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL reset_key: got %0d expected 10", key); end
      nchecks++; if (key_strobe !== 1'b0) begin nerrors++; $display("FAIL reset_strobe: got %b expected 0", key_strobe); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_idle_scan;
      logic [2:0] exp_col;
      start('0);
      wait_cyc(15);
      nchecks++; if (col !== 3'b001) begin nerrors++; $display("FAIL idle_col_first: got %b expected 001", col); end
      for (int n = 1; n <= 30; n++) begin
         wait_cyc(16 * n);
         exp_col = 3'b001 << (n % 3);
         nchecks++; if (col !== exp_col) begin nerrors++; $display("FAIL idle_col slot %0d: got %b expected %b", n, col, exp_col); end
         nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL idle_key slot %0d: got %0d expected 10", n, key); end
      end
      nchecks++; if (scount !== 0) begin nerrors++; $display("FAIL idle_strobe_count: got %0d expected 0", scount); end
   endtask

   task automatic test_press_release;
      start(12'h010);   // (1,1) = '5'
      wait_cyc(191);
      nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL press_before: got %0d expected 10", key); end
      wait_cyc(192);
      nchecks++; if (key !== 4'd5) begin nerrors++; $display("FAIL press_key: got %0d expected 5", key); end
      nchecks++; if (key_strobe !== 1'b1) begin nerrors++; $display("FAIL press_strobe_hi: got %b expected 1", key_strobe); end
      wait_cyc(193);
      nchecks++; if (key_strobe !== 1'b0) begin nerrors++; $display("FAIL press_strobe_lo: got %b expected 0", key_strobe); end
      pressed = '0;
      wait_cyc(383);
      nchecks++; if (key !== 4'd5) begin nerrors++; $display("FAIL release_before: got %0d expected 5", key); end
      wait_cyc(384);
      nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL release_key: got %0d expected 10", key); end
      wait_cyc(450);
      nchecks++; if (scount !== 1) begin nerrors++; $display("FAIL press_strobe_count: got %0d expected 1", scount); end
   endtask

   task automatic test_bounce;
      start(12'h004);   // (0,2) = '3'
      for (int k = 0; k < 144; k++) begin
         wait_cyc(k);
         pressed = (((k / 20) % 2) == 0) ? 12'h004 : 12'h000;
         if (k % 48 == 47) begin
            nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL bounce_key cyc %0d: got %0d expected 10", k, key); end
         end
      end
      pressed = 12'h004;
      wait_cyc(335);
      nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL bounce_before: got %0d expected 10", key); end
      wait_cyc(336);
      nchecks++; if (key !== 4'd3) begin nerrors++; $display("FAIL bounce_key_final: got %0d expected 3", key); end
      wait_cyc(340);
      nchecks++; if (scount !== 1) begin nerrors++; $display("FAIL bounce_strobe_count: got %0d expected 1", scount); end
   endtask

   task automatic test_hash;
      start(12'h800);   // (3,2) = '#'
      for (int n = 1; n <= 5; n++) begin
         wait_cyc(48 * n);
         nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL hash_key scan %0d: got %0d expected 10", n, key); end
      end
      nchecks++; if (scount !== 0) begin nerrors++; $display("FAIL hash_strobe_count: got %0d expected 0", scount); end
   endtask

   task automatic test_multi;
      logic [3:0] exp_key;
      int         exp_strobes;
`ifdef KEYSCAN_MULTI_REJECT_EN
      exp_key     = 4'd10;
      exp_strobes = 0;
`else
      exp_key     = 4'd1;
      exp_strobes = 1;
`endif
      start(12'h101);   // (0,0) = '1' and (2,2) = '9'
      wait_cyc(191);
      nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL multi_before: got %0d expected 10", key); end
      wait_cyc(192);
      nchecks++; if (key !== exp_key) begin nerrors++; $display("FAIL multi_key: got %0d expected %0d", key, exp_key); end
      wait_cyc(300);
      nchecks++; if (key !== exp_key) begin nerrors++; $display("FAIL multi_key_late: got %0d expected %0d", key, exp_key); end
      nchecks++; if (scount !== exp_strobes) begin nerrors++; $display("FAIL multi_strobe_count: got %0d expected %0d", scount, exp_strobes); end
   endtask

   task automatic test_async_reset;
      start(12'h040);   // (2,0) = '7'
      wait_cyc(192);
      nchecks++; if (key !== 4'd7) begin nerrors++; $display("FAIL areset_held: got %0d expected 7", key); end
      wait_cyc(270);
      nchecks++; if (col !== 3'b010) begin nerrors++; $display("FAIL areset_col_pre: got %b expected 010", col); end
      #2 reset = 1'b1;
      #1;
      nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL areset_key: got %0d expected 10", key); end
      nchecks++; if (col !== 3'b001) begin nerrors++; $display("FAIL areset_col: got %b expected 001", col); end
      nchecks++; if (key_strobe !== 1'b0) begin nerrors++; $display("FAIL areset_strobe: got %b expected 0", key_strobe); end
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(191);
      nchecks++; if (key !== 4'd10) begin nerrors++; $display("FAIL areset_before: got %0d expected 10", key); end
      wait_cyc(192);
      nchecks++; if (key !== 4'd7) begin nerrors++; $display("FAIL areset_rekey: got %0d expected 7", key); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle_scan();
      test_press_release();
      test_bounce();
      test_hash();
      test_multi();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/aclk_keyscan.md
AClk_KEYSCAN -- requirements
Module: aclk_keyscan

Interface
REQ-001 Parameter SCAN_DIV, default 16: clk cycles per column slot; legal 4..255.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive full scans needed to accept a press or a release; legal 2..15.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 row  input  4  keypad row sense, active-high, asynchronous to clk; row0 is the top row.
REQ-006 col  output  3  keypad column drive, one-hot, active-high; col0 is the left column.
REQ-007 key  output  4  debounced key code 0..9; 4'd10 = no key; feeds the controller's key input.
REQ-008 key_strobe  output  1  one-clk pulse when a new key is accepted.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer before any use.
REQ-010 Slot counter SHALL count 0..SCAN_DIV-1; col SHALL rotate col0->col1->col2->col0 when the counter wraps.
REQ-011 Synchronized row SHALL be sampled only at slot count SCAN_DIV-1 of each column.
REQ-012 A full scan ends at slot count SCAN_DIV-1 of col2; the scan result SHALL be evaluated at that edge.
REQ-013 Keymap (row,col): (0,0..2)=1,2,3; (1,0..2)=4,5,6; (2,0..2)=7,8,9; (3,1)=0; (3,0) '*' and (3,2) '#' SHALL decode as none (10).
REQ-014 With more than one key in a scan, the result SHALL follow REQ-029/REQ-030.
REQ-015 FSM states: IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE; cand register 4 bits; debounce counter 4 bits; FSM changes state only at scan end.
REQ-016 IDLE: result!=10 -> CONFIRM_PRESS, cand=result, cnt=1; else stay.
REQ-017 CONFIRM_PRESS: result==cand -> cnt+1; when cnt+1==DEBOUNCE_SCANS -> HELD. result!=cand -> IDLE, cnt=0.
REQ-018 HELD: result!=cand -> CONFIRM_RELEASE, cnt=1; else stay.
REQ-019 CONFIRM_RELEASE: result==cand -> HELD, cnt=0; else cnt+1; when cnt+1==DEBOUNCE_SCANS -> IDLE.
REQ-020 key SHALL equal cand in HELD and CONFIRM_RELEASE, and 10 in IDLE and CONFIRM_PRESS; key is registered.
REQ-021 key_strobe SHALL be high for exactly the one clk following the CONFIRM_PRESS->HELD transition.
REQ-022 A different digit pressed while in HELD SHALL NOT change key until a full release is accepted (REQ-019) and a new press is confirmed.
REQ-023 Press latency: key SHALL update at most (DEBOUNCE_SCANS+1)*3*SCAN_DIV+3 clks after row becomes stable.
REQ-024 The slot counter and col rotation SHALL run continuously, independent of FSM state.

Reset
REQ-025 On reset: col=3'b001, slot counter=0, synchronizer=0, FSM=IDLE, cand=10, cnt=0, key=4'd10, key_strobe=0.
REQ-026 Reset asserted mid-debounce or in HELD SHALL force REQ-025 values immediately, without waiting for a clock edge.
REQ-027 After reset deasserts, the first scan SHALL start at col0 with slot count 0.

Configuration
REQ-028 Macro KEYSCAN_MULTI_REJECT_EN selects the multi-key policy.
REQ-029 Defined: a scan with 2 or more decoded digit keys SHALL yield result 10 (rejected).
REQ-030 Undefined: a scan with multiple keys SHALL yield the digit found first in col0->col2 order, and row0->row3 within a column.

Verification
REQ-031 Reset, row=0 for 10 scans -> col rotates every 16 clks; key stays 10; key_strobe never high.
REQ-032 Hold (1,1) stable -> key=5 within 243 clks; exactly one key_strobe pulse; release -> key=10 after 4 scans.
REQ-033 (0,2) bounces, toggling every 20 clks for 3 scans, then stable -> no key change during bounce; key=3 after 4 stable scans.
REQ-034 Press '#' (3,2) held -> key stays 10; no strobe.
REQ-035 Press (0,0) and (2,2) together -> key=1 without macro; key=10 and no strobe with KEYSCAN_MULTI_REJECT_EN.
REQ-036 Assert reset while key=7 is HELD -> key=10, col=001 asynchronously; key=7 reappears after 4 scans once reset is released.
